// File: rtl/demux_lane_fifo.sv
// Two-lane receive buffer behind the 1-to-2 demux; each lane feeds its own show-ahead FIFO, 1-cycle write-to-valid, no bypass.
// in_ready drops while the selected lane is full (a same-cycle pop does not free the slot); ovf_err latches a dropped word.

module lane_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              full,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              rd_rdy,
  output logic [CNT_W-1:0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_fire;
  logic              rd_fire;

  // full comes only from the registered count, so a pop never unblocks a write in the same cycle
  assign full    = (cnt == CNT_W'(DEPTH));
  assign rd_vld  = (cnt != '0);
  assign rd_dat  = mem[rd_ptr];
  assign wr_fire = wr_vld & ~full;
  assign rd_fire = rd_vld & rd_rdy;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      if (wr_fire && !rd_fire)      cnt <= cnt + CNT_W'(1);
      else if (!wr_fire && rd_fire) cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

module demux_lane_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] y1,
  output logic              in_ready,
  output logic              out0_valid,
  output logic [DATA_W-1:0] out0_data,
  input  logic              out0_ready,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  input  logic              out1_ready,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic              ovf_err
);
  logic full0;
  logic full1;
  logic wr0_vld;
  logic wr1_vld;

  assign in_ready = in_sel ? ~full1 : ~full0;
  // the unselected lane's bus is ignored even if the demux leaves it non-zero
  assign wr0_vld  = in_valid & ~in_sel & ~full0;
  assign wr1_vld  = in_valid &  in_sel & ~full1;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane0 (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (wr0_vld),
    .wr_dat (y0),
    .full   (full0),
    .rd_vld (out0_valid),
    .rd_dat (out0_data),
    .rd_rdy (out0_ready),
    .count  (count0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane1 (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (wr1_vld),
    .wr_dat (y1),
    .full   (full1),
    .rd_vld (out1_valid),
    .rd_dat (out1_data),
    .rd_rdy (out1_ready),
    .count  (count1)
  );

  always_ff @(posedge clk) begin
    if (rst)                       ovf_err <= 1'b0;
    else if (in_valid && !in_ready) ovf_err <= 1'b1;
  end
endmodule

// File: tb/tb_demux_lane_fifo.sv
// Randomized and directed bench for demux_lane_fifo against a queue-based model of the two lanes.
module tb_demux_lane_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sel = 1'b0;
  logic [63:0] y0 = '0;
  logic [63:0] y1 = '0;
  logic        in_ready;
  logic        out0_valid;
  logic [63:0] out0_data;
  logic        out0_ready = 1'b0;
  logic        out1_valid;
  logic [63:0] out1_data;
  logic        out1_ready = 1'b0;
  logic [2:0]  count0;
  logic [2:0]  count1;
  logic        ovf_err;

  int total = 0;
  int bad = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] pop0_log[$];
  bit          m_ovf = 0;
  bit          m_rdy;
  bit          chk_en = 0;

  demux_lane_fifo #(.DATA_W(64), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .y0         (y0),
    .y1         (y1),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lane model: a full lane refuses the word; pops and the accepted push apply at the edge.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_ovf  = 0;
      chk_en = 1;
    end else if (chk_en) begin
      m_rdy = in_sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
      if (in_valid && !m_rdy) m_ovf = 1;
      if (out0_ready && q0.size() > 0) begin
        pop0_log.push_back(q0[0]);
        void'(q0.pop_front());
      end
      if (out1_ready && q1.size() > 0) void'(q1.pop_front());
      if (in_valid && m_rdy) begin
        if (in_sel) q1.push_back(y1);
        else        q0.push_back(y0);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("out0_valid", out0_valid, q0.size() != 0);
      chk("out1_valid", out1_valid, q1.size() != 0);
      chk("count0", count0, q0.size());
      chk("count1", count1, q1.size());
      chk("ovf_err", ovf_err, m_ovf);
      chk("in_ready", in_ready, in_sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH));
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    end
  end

  task automatic cyc(input bit v, input bit s, input logic [63:0] d0, input logic [63:0] d1,
                     input bit r0, input bit r1);
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    y0         = d0;
    y1         = d1;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 0; in_sel = 0; out0_ready = 0; out1_ready = 0; y0 = '0; y1 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pushed;
    int c;

    // 1: single lane-0 word, visible one edge later
    do_reset();
    #3;
    chk("t1_ready_after_reset", in_ready, 1);
    chk("t1_count0_reset", count0, 0);
    cyc(1, 0, 64'hA0, 64'h5555, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t1_out0_valid", out0_valid, 1);
    chk("t1_out0_data", out0_data, 64'hA0);
    chk("t1_count0", count0, 1);
    chk("t1_out1_valid", out1_valid, 0);
    chk("t1_count1", count1, 0);

    // 2: fill lane 1, then overflow it
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, 1, {$urandom, $urandom}, 64'(i), 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    #3;
    chk("t2_ready_sel1_full", in_ready, 0);
    chk("t2_count1_full", count1, 4);
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t2_ready_sel0", in_ready, 1);
    cyc(1, 1, 64'h77, 64'h5, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t2_ovf_set", ovf_err, 1);
    chk("t2_count1_held", count1, 4);

    // 3: pop on a full lane does not admit the same-cycle write
    cyc(1, 1, 0, 64'h5, 0, 1);
    cyc(1, 1, 0, 64'h5, 0, 0);
    #3;
    chk("t3_count1_after_pop", count1, 3);
    chk("t3_head_after_pop", out1_data, 64'h2);
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t3_count1_refill", count1, 4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t3_count1_drained", count1, 0);

    // 4: wrap-around on lane 0 with random consumer stalls
    do_reset();
    pop0_log.delete();
    pushed = 0;
    for (c = 0; c < 300 && (pushed < 10 || q0.size() != 0); c++) begin
      @(negedge clk);
      in_valid   = (pushed < 10);
      in_sel     = 0;
      y0         = 64'h10 + 64'(pushed);
      y1         = {$urandom, $urandom};
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 0;
      if (pushed < 10 && q0.size() != DEPTH) pushed++;
    end
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t4_loop_in_budget", c < 300, 1);
    chk("t4_pop_count", pop0_log.size(), 10);
    for (int i = 0; i < 10 && i < pop0_log.size(); i++) chk("t4_order", pop0_log[i], 64'h10 + 64'(i));
    chk("t4_count0_zero", count0, 0);

    // 5: alternating lanes, both consumers always ready
    do_reset();
    cyc(1, 0, 64'hA, 64'hDEAD, 1, 1);
    cyc(1, 1, 64'hBEEF, 64'hB, 1, 1);
    #3;
    chk("t5_a_valid", out0_valid, 1);
    chk("t5_a_data", out0_data, 64'hA);
    chk("t5_l1_empty", out1_valid, 0);
    cyc(1, 0, 64'hC, 64'hF00D, 1, 1);
    #3;
    chk("t5_b_data", out1_data, 64'hB);
    chk("t5_l0_empty", out0_valid, 0);
    cyc(1, 1, 64'h1234, 64'hD, 1, 1);
    #3;
    chk("t5_c_data", out0_data, 64'hC);
    chk("t5_l1_empty2", out1_valid, 0);
    cyc(0, 0, 0, 0, 1, 1);
    #3;
    chk("t5_d_data", out1_data, 64'hD);
    chk("t5_l0_empty2", out0_valid, 0);

    // 6: reset mid-operation clears everything
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'(i + 100), 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 64'(i + 200), 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    #3;
    chk("t6_pre_count0", count0, 3);
    chk("t6_pre_count1", count1, 2);
    chk("t6_pre_ovf", ovf_err, 1);
    do_reset();
    #3;
    chk("t6_count0", count0, 0);
    chk("t6_count1", count1, 0);
    chk("t6_valid0", out0_valid, 0);
    chk("t6_valid1", out1_valid, 0);
    chk("t6_ovf", ovf_err, 0);
    chk("t6_ready", in_ready, 1);

    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 199) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      in_sel     = 1'($urandom_range(0, 1));
      y0         = {$urandom, $urandom};
      y1         = {$urandom, $urandom};
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rst = 0; in_valid = 0; out0_ready = 0; out1_ready = 0;
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_lane_fifo.md
Name: demux_lane_fifo

Overview:
- Downstream stage of the 64-bit 1-to-2 lane demultiplexer.
- Captures the demux outputs y0/y1 under a valid/ready handshake and queues each lane in its own independent FIFO.
- Presents each lane to its consumer through a separate valid/ready port, so the two consumers can stall independently.
- The upstream demux drives zero on the unselected lane; this block writes only the lane named by in_sel and ignores the other lane's data.

Parameters:
DATA_W, 64, lane data width (matches demux width)
DEPTH, 4, entries per lane FIFO; power of two, 2..64
CNT_W, $clog2(DEPTH)+1, width of per-lane occupancy count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream word present on y0/y1
in_sel  input  1  lane select presented to the demux with the word (0 -> y0, 1 -> y1)
y0  input  DATA_W  demux lane-0 output
y1  input  DATA_W  demux lane-1 output
in_ready  output  1  selected lane can accept a word this cycle
out0_valid  output  1  lane-0 FIFO non-empty
out0_data  output  DATA_W  lane-0 head word
out0_ready  input  1  lane-0 consumer accepts head
out1_valid  output  1  lane-1 FIFO non-empty
out1_data  output  DATA_W  lane-1 head word
out1_ready  input  1  lane-1 consumer accepts head
count0  output  CNT_W  lane-0 occupancy
count1  output  CNT_W  lane-1 occupancy
ovf_err  output  1  sticky: in_valid asserted while in_ready low

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, rst. There is no asynchronous reset path.

Reset (rst=1 at a clk edge):
- All pointers and counts go to 0; out0_valid=out1_valid=0; ovf_err=0.
- FIFO storage is not reset.
- out*_data are don't-care while empty.
- Reset mid-operation discards all queued words. in_ready reads 1 in the first cycle after reset release.

Write side:
- in_ready = ~full[in_sel], combinational from in_sel and the registered full flag only.
- A pop in the same cycle does NOT free a slot for the write. A full lane stays not-ready for one cycle after a pop.
- Write fires when in_valid & in_ready. The word taken is y1 if in_sel else y0.
- The write goes to mem_lane[wr_ptr], and the lane's wr_ptr increments modulo DEPTH.
- The unselected lane is untouched.
- If in_valid & ~in_ready, ovf_err is set and the word is not written. ovf_err stays set until rst.

Read side (per lane, fully independent):
- Show-ahead FIFO: outN_valid = (countN != 0); outN_data = mem_laneN[rd_ptrN], combinational from storage.
- Pop fires when outN_valid & outN_ready. rd_ptrN increments modulo DEPTH.
- outN_ready while empty has no effect.

Latency and counts:
- Write-to-valid latency is 1 cycle. A word accepted at edge k is visible on outN_valid/outN_data after edge k.
- There is no bypass from the input to the outputs.
- countN update each edge: +1 on write only, -1 on pop only, unchanged on both or neither. Range is 0..DEPTH.
- fullN = (countN == DEPTH) and is registered-derived.

Boundary cases:
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Ordering is strict FIFO per lane.
- Simultaneous write and pop on the same non-full lane: both happen and the count is unchanged.
- Simultaneous write and pop on the same empty lane cannot occur, because the lane is not valid yet.
- Simultaneous pops on both lanes are allowed.
- A write to one lane concurrent with a pop on the other lane is allowed.
- Words are never reordered across the two lanes' outputs relative to their own lane.

Test Plan:
1. Reset, then write 0x0000_0000_0000_00A0 with in_sel=0 -> after 1 edge out0_valid=1, out0_data=0xA0, count0=1, out1_valid=0, count1=0.
2. Fill lane 1 with words 1,2,3,4 (DEPTH=4) and out1_ready=0 -> in_ready=0 whenever in_sel=1 while in_ready=1 with in_sel=0, count1=4. A 5th write attempt sets ovf_err=1 and count1 stays 4.
3. Full lane 1, assert out1_ready together with in_valid,in_sel=1 -> pop of word 1 happens, write rejected, count1=3. On the next cycle the write is accepted and count1=4.
4. Wrap test: push and pop 10 sequential words 0x10..0x19 on lane 0 with random out0_ready -> output sequence exactly 0x10..0x19 and count0 returns to 0.
5. Interleaved lanes: in_sel alternates 0,1,0,1 with words 0xA,0xB,0xC,0xD and both readys held 1 -> lane 0 emits 0xA,0xC and lane 1 emits 0xB,0xD, each one cycle after its write, with no cross-lane corruption.
6. Assert rst for 1 cycle with count0=3, count1=2 and ovf_err=1 -> next cycle counts are 0, both valids are 0, ovf_err=0 and in_ready=1.
